systolic_ctrl: RTL and testbench



---
 rtl/systolic_pkg.sv | 19 +
 rtl/systolic_clear_skew.sv | 28 ++
 rtl/systolic_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the output-stationary systolic array sequencer.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Operand value the buffers present while their registered read enable is low.
    localparam logic [7:0] FP8_ZERO = 8'h00;

    // Cycles for the last operand to ripple from PE(0,0) to PE(N-1,N-1).
    function automatic int unsigned flush_len(input int unsigned n);
        return (2 * n) - 1;
    endfunction

endpackage

// File: rtl/systolic_clear_skew.sv
// Diagonal accumulator-clear generator: bit d of pe_clear fires d+1 cycles after the seed.
module systolic_clear_skew
    import systolic_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed,
    output logic [2*N-2:0]   pe_clear
);

    localparam int DW = int'(flush_len(N));

    logic [DW-1:0] r_sr;

    // Shift the seed one anti-diagonal further each cycle, independent of FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= {DW{1'b0}};
        end else begin
            r_sr <= {r_sr[DW-2:0], seed};
        end
    end

    assign pe_clear = r_sr;

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for an NxN output-stationary systolic array (feed, flush, row drain).
// Optional performance counters are built when SYSTOLIC_PERF_CNT_EN is defined.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N  = 4,
    parameter int KW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KW-1:0]           cfg_k,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    output logic                    rd_en,
    output logic [KW-1:0]           rd_addr,
    output logic [2*N-2:0]          pe_clear,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef SYSTOLIC_PERF_CNT_EN
    output logic [31:0]             perf_busy_cycles,
    output logic [31:0]             perf_stall_cycles,
`endif
    output logic [$clog2(N)-1:0]    out_row
);

    localparam int          RW        = $clog2(N);
    localparam int unsigned FLUSH_LEN = flush_len(N);
    localparam int          FW        = $clog2(FLUSH_LEN);

    state_e          r_state;
    state_e          w_next;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   r_cnt;
    logic [FW-1:0]   r_fcnt;
    logic [RW-1:0]   r_row;
    logic            r_done;
    logic            r_cfg_err;

    logic            w_accept;
    logic            w_zero_req;
    logic            w_feed_last;
    logic            w_flush_last;
    logic            w_last_hs;
    logic            w_seed;

    assign w_accept     = (r_state == ST_IDLE) && start && (cfg_k != {KW{1'b0}});
    assign w_zero_req   = (r_state == ST_IDLE) && start && (cfg_k == {KW{1'b0}});
    // r_cnt tops out at K-1, so even K = 2^KW-1 never wraps the read address.
    assign w_feed_last  = (r_state == ST_FEED) && (r_cnt == (r_k - KW'(1)));
    assign w_flush_last = (r_state == ST_FLUSH) && (r_fcnt == FW'(FLUSH_LEN - 1));
    assign w_last_hs    = (r_state == ST_DRAIN) && out_ready && (r_row == RW'(N - 1));
    assign w_seed       = (r_state == ST_FEED) && (r_cnt == {KW{1'b0}});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_FEED;
                else          w_next = ST_IDLE;
            end
            ST_FEED: begin
                if (w_feed_last) w_next = ST_FLUSH;
                else             w_next = ST_FEED;
            end
            ST_FLUSH: begin
                if (w_flush_last) w_next = ST_DRAIN;
                else              w_next = ST_FLUSH;
            end
            ST_DRAIN: begin
                if (w_last_hs) w_next = ST_IDLE;
                else           w_next = ST_DRAIN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state and counters.
    always_comb begin
        busy      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = {KW{1'b0}};
        out_valid = 1'b0;
        out_row   = {RW{1'b0}};
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_FEED: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = r_cnt;
            end
            ST_FLUSH: begin
                busy = 1'b1;
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_row   = r_row;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Job length latch and the feed / flush / drain counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k    <= {KW{1'b0}};
            r_cnt  <= {KW{1'b0}};
            r_fcnt <= {FW{1'b0}};
            r_row  <= {RW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) r_k <= cfg_k;
                    else          r_k <= r_k;
                    r_cnt  <= {KW{1'b0}};
                    r_fcnt <= {FW{1'b0}};
                    r_row  <= {RW{1'b0}};
                end
                ST_FEED: begin
                    if (w_feed_last) r_cnt <= r_cnt;
                    else             r_cnt <= r_cnt + KW'(1);
                end
                ST_FLUSH: begin
                    if (w_flush_last) r_fcnt <= {FW{1'b0}};
                    else              r_fcnt <= r_fcnt + FW'(1);
                end
                ST_DRAIN: begin
                    // Row index only moves on a handshake, so it is frozen under backpressure.
                    if (w_last_hs)      r_row <= {RW{1'b0}};
                    else if (out_ready) r_row <= r_row + RW'(1);
                    else                r_row <= r_row;
                end
                default: begin
                    r_cnt <= {KW{1'b0}};
                end
            endcase
        end
    end

    // Single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_done    <= w_last_hs;
            r_cfg_err <= w_zero_req;
        end
    end

    assign done    = r_done;
    assign cfg_err = r_cfg_err;

    systolic_clear_skew #(
        .N (N)
    ) u_clear_skew (
        .clk      (clk),
        .rst      (rst),
        .seed     (w_seed),
        .pe_clear (pe_clear)
    );

`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    // Saturating busy / drain-stall counters, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_busy  <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if ((r_state != ST_IDLE) && (r_perf_busy != 32'hFFFF_FFFF))
                r_perf_busy <= r_perf_busy + 32'd1;
            else
                r_perf_busy <= r_perf_busy;
            if ((r_state == ST_DRAIN) && !out_ready && (r_perf_stall != 32'hFFFF_FFFF))
                r_perf_stall <= r_perf_stall + 32'd1;
            else
                r_perf_stall <= r_perf_stall;
        end
    end

    assign perf_busy_cycles  = r_perf_busy;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: timeline reference model plus row scoreboard.
module tb_systolic_ctrl;

    localparam int N  = 4;
    localparam int KW = 4;
    localparam int RW = 2;
    localparam int DW = 2 * N - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] cfg_k = '0;
    logic          out_ready = 1'b1;
    logic          busy, done, cfg_err, rd_en, out_valid;
    logic [KW-1:0] rd_addr;
    logic [DW-1:0] pe_clear;
    logic [RW-1:0] out_row;
`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0]   perf_busy_cycles, perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    systolic_ctrl #(.N(N), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_k     (cfg_k),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .pe_clear  (pe_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SYSTOLIC_PERF_CNT_EN
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .out_row   (out_row)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Reference model: a job is (t0, K); outputs follow from t = cycle - t0.
    bit      m_active = 1'b0;
    bit      m_started = 1'b0;
    bit      m_done_exp = 1'b0;
    bit      m_err_exp = 1'b0;
    int      m_t0 = 0;
    int      m_k = 0;
    int      m_row = 0;
    longint  m_busy = 0;
    longint  m_stall = 0;
    int      q_rows[$];

    always @(negedge clk) begin : p_model
        int            t;
        bit            en;
        bit            ev;
        bit            was;
        logic [DW-1:0] ec;
        t  = cyc - m_t0;
        en = m_active && (t < m_k);
        ev = m_active && (t >= m_k + 2 * N - 1);
        ec = '0;
        if (m_started && t >= 1 && t <= DW) ec[t-1] = 1'b1;
        if (chk_en) begin
            chk("busy", busy, m_active);
            chk("rd_en", rd_en, en);
            chk("rd_addr", rd_addr, en ? t : 0);
            chk("pe_clear", pe_clear, ec);
            chk("out_valid", out_valid, ev);
            chk("out_row", out_row, ev ? m_row : 0);
            chk("done", done, m_done_exp);
            chk("cfg_err", cfg_err, m_err_exp);
`ifdef SYSTOLIC_PERF_CNT_EN
            if (m_done_exp) begin
                chk("perf_busy", perf_busy_cycles, m_busy);
                chk("perf_stall", perf_stall_cycles, m_stall);
            end
`endif
        end
        if (rst) begin
            m_active = 1'b0; m_started = 1'b0; m_done_exp = 1'b0; m_err_exp = 1'b0;
            m_row = 0; m_busy = 0; m_stall = 0;
            q_rows.delete();
        end else begin
            was = m_active;
            m_done_exp = 1'b0;
            m_err_exp = 1'b0;
            if (was) m_busy++;
            if (ev && !out_ready) m_stall++;
            if (ev && out_ready) begin
                if (m_row == N - 1) begin
                    m_active = 1'b0;
                    m_done_exp = 1'b1;
                end else begin
                    m_row++;
                end
            end
            if (!was && start) begin
                if (cfg_k != '0) begin
                    m_active = 1'b1; m_started = 1'b1;
                    m_t0 = cyc + 1; m_k = int'(cfg_k); m_row = 0;
                    for (int i = 0; i < N; i++) q_rows.push_back(i);
                end else begin
                    m_err_exp = 1'b1;
                end
            end
        end
        cyc++;
    end

    // Scoreboard monitor: every accepted row must match the next expected row index.
    always @(negedge clk) begin : p_sb
        if (chk_en && !rst && out_valid && out_ready) begin
            if (q_rows.size() == 0) chk("row_sb_unexpected", 1, 0);
            else                    chk("row_sb", out_row, q_rows.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int k);
        start = 1'b1;
        cfg_k = KW'(k);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit rnd);
        int i;
        for (i = 0; i < 200; i++) begin
            if (done) break;
            if (rnd) begin
                out_ready = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 7) == 0);
                cfg_k     = KW'($urandom_range(0, 15));
            end
            step();
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk(name, done, 1'b1);
    endtask

    initial begin : p_stim
        int s, cnt, amax, i;
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        chk("reset_busy", busy, 0);
        chk("reset_outs", {rd_en, rd_addr, pe_clear, out_valid, done, cfg_err}, 0);
        rst = 1'b0;
        step();

        // Directed K=3: done lands at t = K + 2N - 1 + N = 14.
        s = cyc;
        start_job(3);
        wait_done("k3_done", 1'b0);
        chk("k3_done_t", cyc - (s + 1), 14);
        step();

        // Backpressure on row 2 for 5 cycles delays done by 5.
        s = cyc;
        start_job(3);
        for (i = 0; i < 40; i++) begin
            if (out_valid && out_row == 2'd2) break;
            step();
        end
        out_ready = 1'b0;
        repeat (5) step();
        chk("bp_row_held", out_row, 2);
        out_ready = 1'b1;
        wait_done("bp_done", 1'b0);
        chk("bp_done_t", cyc - (s + 1), 19);
        step();

        // Zero-length job request.
        start = 1'b1; cfg_k = '0;
        step();
        start = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        step();
        chk("cfg_err_single", {cfg_err, busy, rd_en}, 0);

        // Reset in the middle of a K=8 job, then a fresh K=2 job.
        start_job(8);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_outs", {busy, rd_en, rd_addr, pe_clear, out_valid, done}, 0);
        step();
        start_job(2);
        wait_done("after_rst_done", 1'b0);
        step();

        // Back-to-back: start held high, second job accepted in the done cycle.
        start = 1'b1; cfg_k = 4'd4;
        step();
        cfg_k = 4'd2;
        for (i = 0; i < 100; i++) begin
            if (done) break;
            step();
        end
        chk("b2b_done1", done, 1);
        step();
        start = 1'b0;
        chk("b2b_job2_t0", {busy, rd_en, rd_addr}, {1'b1, 1'b1, 4'd0});
        wait_done("b2b_done2", 1'b0);
        step();

        // Maximum K: full address range without wrap.
        rst = 1'b1;
        step();
        rst = 1'b0;
        start_job(15);
        cnt = 0; amax = 0;
        for (i = 0; i < 200; i++) begin
            if (done) break;
            if (rd_en) begin
                cnt++;
                if (int'(rd_addr) > amax) amax = int'(rd_addr);
            end
            step();
        end
        chk("kmax_rd_cycles", cnt, 15);
        chk("kmax_max_addr", amax, 14);
`ifdef SYSTOLIC_PERF_CNT_EN
        chk("kmax_perf_busy", perf_busy_cycles, 26);
`endif
        step();

        // Randomized jobs with random backpressure and ignored mid-job starts.
        for (int j = 0; j < 25; j++) begin
            start_job($urandom_range(1, 15));
            wait_done("rand_done", 1'b1);
            if ($urandom_range(0, 1) == 0) step();
        end
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
